// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multi-cycle ARM control unit.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, FAULT
    } state_e;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Data-processing command encodings
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Major opcode field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Fault reasons
    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_UNDEF   = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/arm_mc_controller_cond_check.sv
// Condition-code evaluation against the registered NZCV flags.
module arm_cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ok_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    // Unsupported condition codes are treated as "do not execute"
    always_comb begin
        cond_ok_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ok_o = z;
            COND_NE: cond_ok_o = ~z;
            COND_CS: cond_ok_o = c;
            COND_CC: cond_ok_o = ~c;
            COND_MI: cond_ok_o = n;
            COND_PL: cond_ok_o = ~n;
            COND_VS: cond_ok_o = v;
            COND_VC: cond_ok_o = ~v;
            COND_AL: cond_ok_o = 1'b1;
            default: cond_ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multi-cycle ARM control FSM: sequences one instruction over several
// cycles, owns NZCV, waits on memory with a timeout and latches faults.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          USE_MEM_READY  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctl,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [3:0]  flags_q,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;

    state_e          state_q, state_d;
    logic [3:0]      flags_d;
    logic [1:0]      fcode_q, fcode_d;
    logic [CW-1:0]   wait_q, wait_d;

    logic            rdy, cond_ok, in_wait, timeout_hit;
    logic [1:0]      op;
    logic [3:0]      cmd;
    logic            s_bit;
    logic [1:0]      ex_alu;
    logic            ex_legal, ex_cv, ex_cmp;

    assign rdy     = USE_MEM_READY ? mem_ready : 1'b1;
    assign op      = instr[27:26];
    assign cmd     = instr[24:21];
    assign s_bit   = instr[20];
    assign imm_src = instr[27:26];

    arm_cond_check u_cond (
        .cond_i    (instr[31:28]),
        .flags_i   (flags_q),
        .cond_ok_o (cond_ok)
    );

    // Only these states stall on memory and count toward the timeout
    assign in_wait     = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_wait && !rdy
                         && ((32'(wait_q) + 32'd1) >= TIMEOUT_CYCLES);

    // Data-processing command decode: ALU op, legality, C/V update, CMP
    always_comb begin
        ex_alu   = ALU_ADD;
        ex_legal = 1'b1;
        ex_cv    = 1'b0;
        ex_cmp   = 1'b0;
        case (cmd)
            CMD_ADD: ex_cv = 1'b1;
            CMD_SUB: begin ex_alu = ALU_SUB; ex_cv = 1'b1; end
            CMD_AND: ex_alu = ALU_AND;
            CMD_ORR: ex_alu = ALU_ORR;
            // CMP without S would discard its only effect, so it is undefined
            CMD_CMP: begin ex_alu = ALU_SUB; ex_cv = 1'b1; ex_cmp = 1'b1; ex_legal = s_bit; end
            default: ex_legal = 1'b0;
        endcase
    end

    // Next state, flag update, fault latch and wait counter
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        fcode_d = fcode_q;
        wait_d  = (in_wait && !rdy && !timeout_hit && TIMEOUT_CYCLES != 0)
                  ? wait_q + CW'(1) : '0;
        case (state_q)
            FETCH: begin
                if (timeout_hit) begin state_d = FAULT; fcode_d = FC_TIMEOUT; end
                else if (rdy)    state_d = DECODE;
            end
            DECODE: begin
                if (!cond_ok) state_d = FETCH;
                else begin
                    case (op)
                        OP_MEM:  state_d = MEMADR;
                        OP_DP:   state_d = instr[25] ? EXECUTEI : EXECUTER;
                        OP_BR:   state_d = BRANCH;
                        default: begin state_d = FAULT; fcode_d = FC_UNDEF; end
                    endcase
                end
            end
            MEMADR:  state_d = instr[20] ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (timeout_hit) begin state_d = FAULT; fcode_d = FC_TIMEOUT; end
                else if (rdy)    state_d = MEMWB;
            end
            MEMWB:   state_d = FETCH;
            MEMWRITE: begin
                if (timeout_hit) begin state_d = FAULT; fcode_d = FC_TIMEOUT; end
                else if (rdy)    state_d = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                if (!ex_legal) begin
                    state_d = FAULT;
                    fcode_d = FC_UNDEF;
                end else begin
                    if (s_bit) begin
                        flags_d[3:2] = alu_flags[3:2];
                        if (ex_cv) flags_d[1:0] = alu_flags[1:0];
                    end
                    state_d = ex_cmp ? FETCH : ALUWB;
                end
            end
            ALUWB, BRANCH: state_d = FETCH;
            FAULT:         state_d = FAULT;
            default:       state_d = FETCH;
        endcase
    end

    // Moore decode of datapath controls; everything is forced low in reset
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl    = ALU_ADD;
        reg_src    = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_write   = rdy;
            end
            DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMADR:   alu_src_b = 2'b01;
            MEMREAD:  begin mem_read = 1'b1; adr_src = 1'b1; end
            MEMWB:    begin reg_write = 1'b1; result_src = 2'b01; end
            MEMWRITE: begin mem_write = 1'b1; adr_src = 1'b1; reg_src[1] = 1'b1; end
            EXECUTER: alu_ctl = ex_alu;
            EXECUTEI: begin alu_ctl = ex_alu; alu_src_b = 2'b01; end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                reg_src[0] = 1'b1;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_ctl    = ALU_ADD;
            reg_src    = 2'b00;
        end
    end

    assign fault      = (state_q == FAULT);
    assign fault_code = fcode_q;

    // State, flags, fault reason and wait counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            flags_q <= 4'b0000;
            fcode_q <= FC_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            fcode_q <= fcode_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: the driver pushes the expected
// output vector for each cycle, the monitor pops and compares at negedge.
module tb_arm_mc_controller;

    logic        clk, reset, mem_ready;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  result_src, alu_src_b, alu_ctl, imm_src, reg_src, fault_code;
    logic        alu_src_a, fault;
    logic [3:0]  flags_q;

    arm_mc_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
        .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .imm_src(imm_src),
        .reg_src(reg_src), .flags_q(flags_q), .fault(fault), .fault_code(fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int T_RST = 0, T_F = 1, T_D = 2, T_MA = 3, T_MR = 4, T_MWB = 5,
                   T_MW = 6, T_EXR = 7, T_EXI = 8, T_WB = 9, T_BR = 10, T_FLT = 11;
    localparam logic [1:0] A_ADD = 2'b00, A_SUB = 2'b01, A_AND = 2'b10, A_ORR = 2'b11;

    localparam logic [31:0] I_ADD   = 32'hE0845005;
    localparam logic [31:0] I_ADDS  = 32'hE0945005;
    localparam logic [31:0] I_ADDEQ = 32'h00845005;
    localparam logic [31:0] I_ANDS  = 32'hE0145005;
    localparam logic [31:0] I_ORR   = 32'hE1845005;
    localparam logic [31:0] I_ADDI  = 32'hE2845005;
    localparam logic [31:0] I_CMP   = 32'hE1550005;
    localparam logic [31:0] I_LDR   = 32'hE5901000;
    localparam logic [31:0] I_STR   = 32'hE5801000;
    localparam logic [31:0] I_BMI   = 32'h4A000000;
    localparam logic [31:0] I_UND   = 32'hEC000000;

    typedef struct {
        string       nm;
        logic [23:0] v;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_flags;
    logic [1:0] exp_code;
    logic       probe;

    // Expected outputs per state, written from the control table
    function automatic logic [23:0] ev(input int st, input logic rdy, input logic [1:0] alu);
        logic pc, adr, mr, mw, ir, rw, a, flt;
        logic [1:0] rs, b, al, rsrc;
        pc = 0; adr = 0; mr = 0; mw = 0; ir = 0; rw = 0; a = 0; flt = 0;
        rs = 2'b00; b = 2'b00; al = A_ADD; rsrc = 2'b00;
        case (st)
            T_F:   begin pc = rdy; mr = 1; ir = rdy; rs = 2'b10; a = 1; b = 2'b10; end
            T_D:   begin a = 1; b = 2'b10; end
            T_MA:  b = 2'b01;
            T_MR:  begin adr = 1; mr = 1; end
            T_MWB: begin rw = 1; rs = 2'b01; end
            T_MW:  begin adr = 1; mw = 1; rsrc = 2'b10; end
            T_EXR: al = alu;
            T_EXI: begin b = 2'b01; al = alu; end
            T_WB:  rw = 1;
            T_BR:  begin pc = 1; rs = 2'b10; b = 2'b01; rsrc = 2'b01; end
            T_FLT: flt = 1;
            default: ;
        endcase
        return {pc, adr, mr, mw, ir, rw, rs, a, b, al, rsrc, instr[27:26], exp_flags, flt, exp_code};
    endfunction

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(input int st, input logic rdy, input logic [1:0] alu, input string nm);
        exp_t e;
        mem_ready = rdy;
        e.nm = nm;
        e.v  = ev(st, rdy, alu);
        q.push_back(e);
    endtask

    task automatic cy(input int st, input logic rdy, input logic [1:0] alu, input string nm);
        go();
        exp(st, rdy, alu, nm);
    endtask

    task automatic fi(input logic [31:0] ins, input string nm);
        go();
        instr = ins;
        exp(T_F, 1'b1, A_ADD, nm);
    endtask

    // Monitor: compare whatever expectation is pending at each sample point
    initial begin
        exp_t e;
        logic [23:0] act;
        forever begin
            @(negedge clk or posedge probe);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                       result_src, alu_src_a, alu_src_b, alu_ctl, reg_src, imm_src,
                       flags_q, fault, fault_code};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %06h expected %06h", e.nm, act, e.v);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; instr = I_ADD; alu_flags = 4'b0000;
        exp_flags = 4'b0000; exp_code = 2'b00; probe = 1'b0;

        go(); exp(T_RST, 1, A_ADD, "reset");
        // ADD R5,R4,R5
        go(); reset = 1'b1; exp(T_F, 1, A_ADD, "add_f");
        cy(T_D, 1, A_ADD, "add_d");
        cy(T_EXR, 1, A_ADD, "add_ex");
        cy(T_WB, 1, A_ADD, "add_wb");
        // LDR with three stall cycles
        fi(I_LDR, "ldr_f");
        cy(T_D, 1, A_ADD, "ldr_d");
        cy(T_MA, 1, A_ADD, "ldr_ma");
        for (int i = 0; i < 3; i++) cy(T_MR, 0, A_ADD, "ldr_mr_stall");
        cy(T_MR, 1, A_ADD, "ldr_mr");
        cy(T_MWB, 1, A_ADD, "ldr_wb");
        // CMP R5,R5 sets Z
        fi(I_CMP, "cmp_f");
        cy(T_D, 1, A_ADD, "cmp_d");
        go(); alu_flags = 4'b0100; exp(T_EXR, 1, A_SUB, "cmp_ex");
        exp_flags = 4'b0100;
        // ADDS: full NZCV update
        fi(I_ADDS, "adds_f");
        cy(T_D, 1, A_ADD, "adds_d");
        go(); alu_flags = 4'b0010; exp(T_EXR, 1, A_ADD, "adds_ex");
        exp_flags = 4'b0010;
        cy(T_WB, 1, A_ADD, "adds_wb");
        // ADDEQ with Z=0: condition fails, two cycles
        fi(I_ADDEQ, "addeq_f");
        cy(T_D, 1, A_ADD, "addeq_d");
        // ANDS: N,Z update, C,V kept
        fi(I_ANDS, "ands_f");
        cy(T_D, 1, A_ADD, "ands_d");
        go(); alu_flags = 4'b1011; exp(T_EXR, 1, A_AND, "ands_ex");
        exp_flags = 4'b1010;
        cy(T_WB, 1, A_ADD, "ands_wb");
        // BMI taken (N=1)
        fi(I_BMI, "bmi_f");
        cy(T_D, 1, A_ADD, "bmi_d");
        cy(T_BR, 1, A_ADD, "bmi_br");
        // ADD immediate
        fi(I_ADDI, "addi_f");
        cy(T_D, 1, A_ADD, "addi_d");
        cy(T_EXI, 1, A_ADD, "addi_ex");
        cy(T_WB, 1, A_ADD, "addi_wb");
        // ORR register
        fi(I_ORR, "orr_f");
        cy(T_D, 1, A_ADD, "orr_d");
        cy(T_EXR, 1, A_ORR, "orr_ex");
        cy(T_WB, 1, A_ADD, "orr_wb");
        // STR with one stall
        fi(I_STR, "str_f");
        cy(T_D, 1, A_ADD, "str_d");
        cy(T_MA, 1, A_ADD, "str_ma");
        cy(T_MW, 0, A_ADD, "str_mw_stall");
        cy(T_MW, 1, A_ADD, "str_mw");
        // STR aborted by reset in MEMWRITE, checked between clock edges
        fi(I_STR, "strab_f");
        cy(T_D, 1, A_ADD, "strab_d");
        cy(T_MA, 1, A_ADD, "strab_ma");
        cy(T_MW, 0, A_ADD, "strab_mw");
        @(negedge clk); #1;
        reset = 1'b0; exp_flags = 4'b0000;
        #1; exp(T_RST, 0, A_ADD, "strab_async_rst");
        probe = 1'b1; #1; probe = 1'b0;
        // Undefined op=11 -> FAULT code 01, sticky
        go(); reset = 1'b1; instr = I_UND; exp(T_F, 1, A_ADD, "und_f");
        cy(T_D, 1, A_ADD, "und_d");
        exp_code = 2'b01;
        cy(T_FLT, 1, A_ADD, "und_fault");
        cy(T_FLT, 1, A_ADD, "und_hold");
        go(); reset = 1'b0; exp_code = 2'b00; exp(T_RST, 1, A_ADD, "und_rst");
        // FETCH timeout: 16 stalled cycles then FAULT code 10
        go(); reset = 1'b1; instr = I_ADD; exp(T_F, 0, A_ADD, "to_f");
        for (int i = 0; i < 15; i++) cy(T_F, 0, A_ADD, "to_f_wait");
        exp_code = 2'b10;
        cy(T_FLT, 0, A_ADD, "to_fault");
        cy(T_FLT, 1, A_ADD, "to_hold");
        cy(T_FLT, 1, A_ADD, "to_hold2");
        go(); reset = 1'b0; exp_code = 2'b00; exp(T_RST, 1, A_ADD, "to_rst");
        // Normal operation after recovery
        go(); reset = 1'b1; exp(T_F, 1, A_ADD, "rec_f");
        cy(T_D, 1, A_ADD, "rec_d");
        cy(T_EXR, 1, A_ADD, "rec_ex");
        cy(T_WB, 1, A_ADD, "rec_wb");

        go(); go();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
